cpu_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's single-byte bus (cpu_mem_read/write/address). Decodes the address to
//  ROM, RAM or MMIO, and returns read data one cycle after the request, which is what the fetch FSM's

---
 rtl/arch_defs_pkg.sv | 8 +
 rtl/mem_addr_decoder.sv | 23 ++
 rtl/cpu_mem_responder.sv | 111 +++++++++++
 tb/tb_cpu_mem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: memory map constants, region and responder state types
package arch_defs_pkg;
  localparam logic [15:0] DEF_RAM_TOP   = 16'h0FFF;
  localparam logic [15:0] DEF_MMIO_BASE = 16'hE000;
  localparam logic [15:0] DEF_ROM_BASE  = 16'hF000;
  typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_MMIO, REG_NONE} mem_region_t;
  typedef enum logic [1:0] {IDLE, MEM_RESP, MMIO_WAIT, MMIO_RESP} resp_state_t;
endpackage

// File: rtl/mem_addr_decoder.sv
// mem_addr_decoder: maps a CPU address to its region and the offset within it
module mem_addr_decoder
  import arch_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RAM_TOP   = DEF_RAM_TOP,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE  = DEF_ROM_BASE
) (
  input  logic [ADDR_WIDTH-1:0] address,
  output mem_region_t           region,
  output logic [ADDR_WIDTH-1:0] offset
);
  localparam logic [ADDR_WIDTH-1:0] MMIO_TOP = MMIO_BASE + ADDR_WIDTH'(15);
  always_comb begin
    region = address >= ROM_BASE ? REG_ROM :
             (address >= MMIO_BASE && address <= MMIO_TOP) ? REG_MMIO :
             address <= RAM_TOP ? REG_RAM : REG_NONE;
    offset = region == REG_ROM  ? address - ROM_BASE :
             region == REG_MMIO ? address - MMIO_BASE :
             region == REG_RAM  ? address : '0;
  end
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: decodes CPU byte-bus requests to RAM/ROM/MMIO and returns read data one cycle later
module cpu_mem_responder
  import arch_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RAM_TOP   = DEF_RAM_TOP,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE  = DEF_ROM_BASE,
  parameter int MMIO_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0] cpu_mem_address,
  input  logic [DATA_WIDTH-1:0] cpu_mem_wdata,
  output logic [DATA_WIDTH-1:0] cpu_mem_rdata,
  output logic                  cpu_mem_rvalid,
  output logic                  cpu_mem_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic                  mmio_req,
  output logic                  mmio_we,
  output logic [3:0]            mmio_addr,
  output logic [DATA_WIDTH-1:0] mmio_wdata,
  input  logic [DATA_WIDTH-1:0] mmio_rdata,
  input  logic                  mmio_ack,
  output logic                  bus_err,
  input  logic                  err_clear
);
  localparam int CW = $clog2(MMIO_TIMEOUT + 1);
  resp_state_t state, state_nx;
  mem_region_t region, region_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic [3:0] off_q;
  logic we_q, accept, timeout, err_set;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, mem_mux;
  logic [CW-1:0] cnt;
  mem_addr_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH), .RAM_TOP(RAM_TOP), .MMIO_BASE(MMIO_BASE), .ROM_BASE(ROM_BASE)
  ) u_dec (
    .address(cpu_mem_address),
    .region (region),
    .offset (offset)
  );
  assign cpu_mem_ready  = state == IDLE || state == MEM_RESP;
  assign accept         = cpu_mem_ready && (cpu_mem_read || cpu_mem_write);
  assign timeout        = state == MMIO_WAIT && !mmio_ack && cnt == CW'(MMIO_TIMEOUT - 1);
  assign mem_mux        = region_q == REG_RAM ? ram_rdata : region_q == REG_ROM ? rom_rdata : '1;
  assign cpu_mem_rdata  = state == MEM_RESP ? mem_mux : rdata_q;
  assign cpu_mem_rvalid = state == MEM_RESP || (state == MMIO_RESP && !we_q);
  assign ram_addr       = offset;
  assign ram_we         = accept && cpu_mem_write && region == REG_RAM;
  assign ram_wdata      = cpu_mem_wdata;
  assign rom_addr       = cpu_mem_address;
  assign mmio_req       = state == MMIO_WAIT;
  assign mmio_we        = we_q;
  assign mmio_addr      = off_q;
  assign mmio_wdata     = wdata_q;
  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    case (state)
      IDLE, MEM_RESP: begin
        state_nx = IDLE;
        if (accept) begin
          // read+write together is served as a write but still flagged
          err_set  = (cpu_mem_read && cpu_mem_write) || region == REG_NONE ||
                     (region == REG_ROM && cpu_mem_write);
          state_nx = region == REG_MMIO ? MMIO_WAIT : cpu_mem_write ? IDLE : MEM_RESP;
        end
      end
      MMIO_WAIT: begin
        state_nx = mmio_ack ? MMIO_RESP : timeout ? IDLE : MMIO_WAIT;
        err_set  = timeout;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      region_q <= REG_NONE;
      off_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt      <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= err_set || (bus_err && !err_clear);
      cnt     <= state == MMIO_WAIT ? cnt + 1'b1 : '0;
      if (accept) begin
        region_q <= region;
        off_q    <= offset[3:0];
        we_q     <= cpu_mem_write;
        wdata_q  <= cpu_mem_wdata;
      end
      // rdata_q keeps the last response visible after rvalid drops
      if (state == MEM_RESP) rdata_q <= mem_mux;
      else if (state == MMIO_WAIT && mmio_ack && !we_q) rdata_q <= mmio_rdata;
      else if (timeout && !we_q) rdata_q <= '1;
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed checks of cpu_mem_responder with simple RAM/ROM models
module tb_cpu_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
  logic [15:0] cpu_mem_address = '0;
  logic [7:0] cpu_mem_wdata = '0;
  logic [7:0] cpu_mem_rdata;
  logic cpu_mem_rvalid, cpu_mem_ready;
  logic [15:0] ram_addr, rom_addr;
  logic ram_we;
  logic [7:0] ram_wdata, ram_rdata, rom_rdata;
  logic mmio_req, mmio_we;
  logic [3:0] mmio_addr;
  logic [7:0] mmio_wdata;
  logic [7:0] mmio_rdata = '0;
  logic mmio_ack = 1'b0;
  logic bus_err;
  logic err_clear = 1'b0;
  logic [7:0] ram [4096];
  logic [7:0] rom [4096];
  int n_tests = 0, n_fail = 0;
  cpu_mem_responder dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_mem_address(cpu_mem_address), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_rdata(cpu_mem_rdata), .cpu_mem_rvalid(cpu_mem_rvalid), .cpu_mem_ready(cpu_mem_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack),
    .bus_err(bus_err), .err_clear(err_clear)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[11:0]] <= ram_wdata;
    ram_rdata <= ram[ram_addr[11:0]];
    rom_rdata <= rom[rom_addr[11:0]];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    cpu_mem_read = rd;
    cpu_mem_write = wr;
    cpu_mem_address = a;
    cpu_mem_wdata = d;
  endtask
  initial begin
    int n;
    logic [7:0] seen;
    logic got_rv;
    rom[0] = 8'h2A;
    rom[1] = 8'h00;
    rom[2] = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", cpu_mem_rdata, 8'h00);
    check("rst_rvalid", cpu_mem_rvalid, 0);
    check("rst_ready", cpu_mem_ready, 1);
    check("rst_ram_we", ram_we, 0);
    check("rst_mmio_req", mmio_req, 0);
    check("rst_bus_err", bus_err, 0);
    reset = 1'b1;
    tick;
    // single ROM read
    req(1, 0, 16'hF000, 0);
    #1;
    check("rom_addr", rom_addr, 16'hF000);
    tick;
    req(0, 0, 0, 0);
    #1;
    check("rom_rvalid", cpu_mem_rvalid, 1);
    check("rom_rdata", cpu_mem_rdata, 8'h2A);
    tick;
    #1;
    check("rom_rvalid_drop", cpu_mem_rvalid, 0);
    check("rom_rdata_hold", cpu_mem_rdata, 8'h2A);
    // back-to-back ROM reads
    req(1, 0, 16'hF000, 0);
    tick;
    req(1, 0, 16'hF001, 0);
    #1;
    check("b2b_rv0", cpu_mem_rvalid, 1);
    check("b2b_d0", cpu_mem_rdata, 8'h2A);
    check("b2b_ready", cpu_mem_ready, 1);
    tick;
    req(1, 0, 16'hF002, 0);
    #1;
    check("b2b_rv1", cpu_mem_rvalid, 1);
    check("b2b_d1", cpu_mem_rdata, 8'h00);
    tick;
    req(0, 0, 0, 0);
    #1;
    check("b2b_rv2", cpu_mem_rvalid, 1);
    check("b2b_d2", cpu_mem_rdata, 8'h02);
    tick;
    // RAM write then read
    req(0, 1, 16'h0200, 8'h55);
    #1;
    check("ram_we_on", ram_we, 1);
    check("ram_waddr", ram_addr, 16'h0200);
    tick;
    req(1, 0, 16'h0200, 0);
    #1;
    check("ram_we_off", ram_we, 0);
    check("ram_wr_rvalid", cpu_mem_rvalid, 0);
    tick;
    req(0, 0, 0, 0);
    #1;
    check("ram_rvalid", cpu_mem_rvalid, 1);
    check("ram_rdata", cpu_mem_rdata, 8'h55);
    check("ram_bus_err", bus_err, 0);
    tick;
    // ROM write is an error, err_clear clears it
    req(0, 1, 16'hF010, 8'h11);
    #1;
    check("romwr_we", ram_we, 0);
    tick;
    req(0, 0, 0, 0);
    #1;
    check("romwr_err", bus_err, 1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    #1;
    check("err_cleared", bus_err, 0);
    // unmapped write with simultaneous err_clear: error wins
    req(0, 1, 16'h2000, 8'h77);
    err_clear = 1'b1;
    tick;
    req(0, 0, 0, 0);
    err_clear = 1'b0;
    #1;
    check("err_wins", bus_err, 1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    // unmapped read returns FF
    req(1, 0, 16'h2000, 0);
    tick;
    req(0, 0, 0, 0);
    #1;
    check("unm_rvalid", cpu_mem_rvalid, 1);
    check("unm_rdata", cpu_mem_rdata, 8'hFF);
    check("unm_err", bus_err, 1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    // read+write together: treated as a RAM write, flagged
    req(1, 1, 16'h0300, 8'h66);
    #1;
    check("rw_we", ram_we, 1);
    tick;
    req(0, 0, 0, 0);
    #1;
    check("rw_err", bus_err, 1);
    check("rw_rvalid", cpu_mem_rvalid, 0);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    // MMIO read with ack in the third wait cycle
    req(1, 0, 16'hE003, 0);
    tick;
    req(0, 0, 0, 0);
    #1;
    check("mmio_req", mmio_req, 1);
    check("mmio_addr", mmio_addr, 4'h3);
    check("mmio_we", mmio_we, 0);
    n = 0;
    seen = '0;
    got_rv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mmio_ack = (i == 2);
      mmio_rdata = 8'h81;
      #1;
      if (!cpu_mem_ready) n++;
      if (cpu_mem_rvalid) begin
        got_rv = 1'b1;
        seen = cpu_mem_rdata;
      end
      tick;
    end
    mmio_ack = 1'b0;
    check("mmio_busy_cycles", n, 4);
    check("mmio_rvalid_seen", got_rv, 1);
    check("mmio_rdata", seen, 8'h81);
    check("mmio_ok_err", bus_err, 0);
    // MMIO read with no ack times out
    req(1, 0, 16'hE005, 0);
    tick;
    req(0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!mmio_req) break;
      n++;
      tick;
    end
    check("to_req_cycles", n, 8);
    check("to_rdata", cpu_mem_rdata, 8'hFF);
    check("to_err", bus_err, 1);
    check("to_req_off", mmio_req, 0);
    check("to_ready", cpu_mem_ready, 1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    // reset while waiting on MMIO aborts at once
    req(1, 0, 16'hE001, 0);
    tick;
    req(0, 0, 0, 0);
    tick;
    #1;
    check("abort_pre_req", mmio_req, 1);
    reset = 1'b0;
    #1;
    check("abort_req", mmio_req, 0);
    check("abort_ready", cpu_mem_ready, 1);
    check("abort_rvalid", cpu_mem_rvalid, 0);
    tick;
    reset = 1'b1;
    tick;
    #1;
    check("abort_idle_rvalid", cpu_mem_rvalid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
